retention_sequencer: RTL

- PMU-side initiator for the retention register block. It sequences a power-domain shutdown and wake-up around a retention save and restore.
- Sleep sequence: trigger save, wait for save to finish, assert isolation, drop domain power.
- Wake sequence: raise power, wait for pwr_good, trigger restore, release isolation.
- Sits between the PMU power-state controller (sleep_req/wake_req) and the retention block (save_enable/restore_enable/valid).

---
 rtl/pmu_ret_pkg.sv | 28 ++
 rtl/retention_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pmu_ret_pkg.sv
// Shared types and default timing constants for the retention sequencer.
// Contents:
//   ret_seq_state_e - FSM state encoding, also exported on state_o for debug
//   *_DEF           - default isolation delay, timeouts and counter width
package pmu_ret_pkg;

  typedef enum logic [3:0] {
    ON        = 4'd0,
    SAVE_REQ  = 4'd1,
    SAVE_RISE = 4'd2,
    SAVE_FALL = 4'd3,
    ISO_ON    = 4'd4,
    PWR_OFF   = 4'd5,
    OFF       = 4'd6,
    PWR_ON    = 4'd7,
    RST_REQ   = 4'd8,
    RST_RISE  = 4'd9,
    RST_FALL  = 4'd10,
    DEISO     = 4'd11,
    ERR       = 4'd12
  } ret_seq_state_e;

  localparam int ISO_DLY_DEF = 4;     // hold cycles after an isolation change
  localparam int RET_TMO_DEF = 256;   // max cycles per retention valid edge
  localparam int PWR_TMO_DEF = 1024;  // max cycles waiting for pwr_good
  localparam int TMO_W_DEF   = 11;    // counter width, fits all of the above

endpackage

// File: rtl/retention_sequencer.sv
// Retention sequencer: PMU-side initiator that wraps a power-domain shutdown
// and wake-up around a retention save and restore.
//   Sleep: save pulse -> wait valid high/low -> isolate -> drop power -> OFF
//   Wake : raise power -> wait pwr_good -> restore pulse -> wait valid
//          high/low -> de-isolate -> ON (wake_ack pulse)
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sleep_req, wake_req       level requests from the PMU power controller
//   sleep_ack                 high while the domain is OFF
//   wake_ack                  one-cycle pulse on DEISO -> ON
//   save_enable/restore_enable one-cycle pulses to the retention block
//   ret_valid                 retention block busy/valid
//   iso_en, pwr_en            domain isolation and power switch enables
//   pwr_good                  domain power-good (synchronous to clk)
//   err, err_clr              sticky timeout/power error and its clear
//   state_o                   current FSM state for debug
module retention_sequencer
  import pmu_ret_pkg::*;
#(
  parameter int ISO_DLY = ISO_DLY_DEF,
  parameter int RET_TMO = RET_TMO_DEF,
  parameter int PWR_TMO = PWR_TMO_DEF,
  parameter int TMO_W   = TMO_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  output logic       sleep_ack,
  output logic       wake_ack,
  output logic       save_enable,
  output logic       restore_enable,
  input  logic       ret_valid,
  output logic       iso_en,
  output logic       pwr_en,
  input  logic       pwr_good,
  output logic       err,
  input  logic       err_clr,
  output logic [3:0] state_o
);

  // Counter values seen on the last cycle of a timed wait: the state has then
  // spent exactly N cycles since entry.
  localparam logic [TMO_W-1:0] ISO_LAST = TMO_W'(ISO_DLY - 1);
  localparam logic [TMO_W-1:0] RET_LAST = TMO_W'(RET_TMO - 1);
  localparam logic [TMO_W-1:0] PWR_LAST = TMO_W'(PWR_TMO - 1);
  localparam logic [TMO_W-1:0] CNT_MAX  = {TMO_W{1'b1}};

  ret_seq_state_e   state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             err_set_s;

  logic sleep_ack_q, sleep_ack_d;
  logic wake_ack_q, wake_ack_d;
  logic save_q, save_d;
  logic restore_q, restore_d;
  logic iso_q, iso_d;
  logic pwr_q, pwr_d;

  // State, cycle counter and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ON;
      cnt_q   <= {TMO_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; pwr_good loss during restore outranks every other exit.
  always_comb begin
    state_d   = state_q;
    err_set_s = 1'b0;
    case (state_q)
      ON: begin
        // wake_req is deliberately ignored here, so sleep wins a tie
        if (sleep_req) state_d = SAVE_REQ;
        else           state_d = ON;
      end
      SAVE_REQ: state_d = SAVE_RISE;
      SAVE_RISE: begin
        if (ret_valid) begin
          state_d = SAVE_FALL;
        end else if (cnt_q == RET_LAST) begin
          // abort the sleep: domain stays powered and un-isolated
          state_d   = ON;
          err_set_s = 1'b1;
        end else begin
          state_d = SAVE_RISE;
        end
      end
      SAVE_FALL: begin
        if (!ret_valid) begin
          state_d = ISO_ON;
        end else if (cnt_q == RET_LAST) begin
          state_d   = ON;
          err_set_s = 1'b1;
        end else begin
          state_d = SAVE_FALL;
        end
      end
      ISO_ON: begin
        if (cnt_q == ISO_LAST) state_d = PWR_OFF;
        else                   state_d = ISO_ON;
      end
      PWR_OFF: state_d = OFF;
      OFF: begin
        if (wake_req) state_d = PWR_ON;
        else          state_d = OFF;
      end
      PWR_ON: begin
        if (pwr_good) begin
          state_d = RST_REQ;
        end else if (cnt_q == PWR_LAST) begin
          state_d   = ERR;
          err_set_s = 1'b1;
        end else begin
          state_d = PWR_ON;
        end
      end
      RST_REQ: begin
        if (!pwr_good) begin
          state_d   = ERR;
          err_set_s = 1'b1;
        end else begin
          state_d = RST_RISE;
        end
      end
      RST_RISE: begin
        if (!pwr_good || (!ret_valid && (cnt_q == RET_LAST))) begin
          state_d   = ERR;
          err_set_s = 1'b1;
        end else if (ret_valid) begin
          state_d = RST_FALL;
        end else begin
          state_d = RST_RISE;
        end
      end
      RST_FALL: begin
        if (!pwr_good || (ret_valid && (cnt_q == RET_LAST))) begin
          state_d   = ERR;
          err_set_s = 1'b1;
        end else if (!ret_valid) begin
          state_d = DEISO;
        end else begin
          state_d = RST_FALL;
        end
      end
      DEISO: begin
        if (!pwr_good) begin
          state_d   = ERR;
          err_set_s = 1'b1;
        end else if (cnt_q == ISO_LAST) begin
          state_d = ON;
        end else begin
          state_d = DEISO;
        end
      end
      ERR: begin
        if (err_clr) state_d = DEISO;
        else         state_d = ERR;
      end
      default: state_d = ON;
    endcase
  end

  // Counter restarts on every state change and saturates; err set beats clear.
  always_comb begin
    if (state_d != state_q)  cnt_d = {TMO_W{1'b0}};
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + TMO_W'(1);
    else                     cnt_d = cnt_q;

    if (err_set_s)    err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  // Output decode from the next state so registered outputs align with state_q.
  always_comb begin
    sleep_ack_d = 1'b0;
    wake_ack_d  = 1'b0;
    save_d      = 1'b0;
    restore_d   = 1'b0;
    iso_d       = 1'b0;
    pwr_d       = 1'b1;
    case (state_d)
      ON:        wake_ack_d = (state_q == DEISO) ? 1'b1 : 1'b0;
      SAVE_REQ:  save_d     = 1'b1;
      SAVE_RISE, SAVE_FALL, DEISO: iso_d = 1'b0;
      ISO_ON:    iso_d      = 1'b1;
      PWR_OFF: begin
        iso_d = 1'b1;
        pwr_d = 1'b0;
      end
      OFF: begin
        sleep_ack_d = 1'b1;
        iso_d       = 1'b1;
        pwr_d       = 1'b0;
      end
      RST_REQ: begin
        restore_d = 1'b1;
        iso_d     = 1'b1;
      end
      PWR_ON, RST_RISE, RST_FALL, ERR: iso_d = 1'b1;
      default: iso_d = 1'b0;
    endcase
  end

  // Output registers; reset values match the ON state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sleep_ack_q <= 1'b0;
      wake_ack_q  <= 1'b0;
      save_q      <= 1'b0;
      restore_q   <= 1'b0;
      iso_q       <= 1'b0;
      pwr_q       <= 1'b1;
    end else begin
      sleep_ack_q <= sleep_ack_d;
      wake_ack_q  <= wake_ack_d;
      save_q      <= save_d;
      restore_q   <= restore_d;
      iso_q       <= iso_d;
      pwr_q       <= pwr_d;
    end
  end

  assign sleep_ack      = sleep_ack_q;
  assign wake_ack       = wake_ack_q;
  assign save_enable    = save_q;
  assign restore_enable = restore_q;
  assign iso_en         = iso_q;
  assign pwr_en         = pwr_q;
  assign err            = err_q;
  assign state_o        = state_q;

endmodule
